// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (LSB first, idle high) feeding a first-word-fall-through receive FIFO.
// Bytes appear at rdata one cycle after the stop-bit sample; overrun/frame_err are sticky until clr.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 8,
  parameter int CW           = 4
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          rx,
  input  logic          rd,
  input  logic          clr,
  output logic [7:0]    rdata,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          overrun,
  output logic          frame_err
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(CLKS_PER_BIT);
  localparam logic [CNTW-1:0] HALF_M1 = CNTW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNTW-1:0] FULL_M1 = CNTW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t          state, state_n;
  logic [CNTW-1:0] clk_cnt, clk_n;
  logic [2:0]      bit_cnt, bit_n;
  logic [7:0]      shift, shift_n;
  logic            rx_meta, rx_s;
  logic            push, ferr_evt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          pop, wr, ovr_evt;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state   <= S_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_n;
      bit_cnt <= bit_n;
      shift   <= shift_n;
    end
  end

  always_comb begin
    state_n  = state;
    clk_n    = clk_cnt;
    bit_n    = bit_cnt;
    shift_n  = shift;
    push     = 1'b0;
    ferr_evt = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_n = S_START;
          clk_n   = '0;
        end
      end
      S_START: begin
        // Re-check the line at mid start bit so short low pulses are ignored.
        if (clk_cnt == HALF_M1) begin
          if (rx_s) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_DATA;
            bit_n   = '0;
            clk_n   = '0;
          end
        end else begin
          clk_n = clk_cnt + CNTW'(1);
        end
      end
      S_DATA: begin
        if (clk_cnt == FULL_M1) begin
          clk_n            = '0;
          shift_n[bit_cnt] = rx_s;
          if (bit_cnt == 3'd7) state_n = S_STOP;
          else                 bit_n   = bit_cnt + 3'd1;
        end else begin
          clk_n = clk_cnt + CNTW'(1);
        end
      end
      S_STOP: begin
        if (clk_cnt == FULL_M1) begin
          clk_n = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_n = S_IDLE;
          end else begin
            ferr_evt = 1'b1;
            state_n  = S_BREAK;
          end
        end else begin
          clk_n = clk_cnt + CNTW'(1);
        end
      end
      S_BREAK: begin
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop     = rd && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr      = push && (!full || pop);
  assign ovr_evt = push && full && !pop;
  assign rdata   = mem[rptr];

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wptr] <= shift;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      case ({wr, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overrun   <= (overrun & ~clr) | ovr_evt;
      frame_err <= (frame_err & ~clr) | ferr_evt;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames driven with known timing, a queue model of the FIFO and flags
// compared every cycle, plus literal expectations for each scenario.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;
  localparam int LAT   = 3 + CPB / 2 + 9 * CPB;  // start edge -> stop-sample edge

  logic       HCLK = 1'b0;
  logic       HRESETn, rx, rd, clr;
  logic [7:0] rdata;
  logic       empty, full, overrun, frame_err;
  logic [3:0] count;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .CW(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .rx(rx), .rd(rd), .clr(clr),
    .rdata(rdata), .empty(empty), .full(full), .count(count),
    .overrun(overrun), .frame_err(frame_err)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {int at; logic [7:0] b; bit ok;} ev_t;

  int         n_chk = 0, n_fail = 0, cyc = 0, last_push = 0;
  logic [7:0] mq[$];
  ev_t        sched[$];
  ev_t        ev;
  bit         ov_m = 0, fe_m = 0, model_on = 0, popm, ev_ok, ev_bad, rnd_done;
  logic [7:0] ev_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one step per clock edge, from the observable rules only.
  initial forever begin
    @(posedge HCLK);
    cyc++;
    if (!HRESETn) begin
      mq.delete();
      sched.delete();
      ov_m = 0;
      fe_m = 0;
      model_on = 1;
    end else begin
      popm = rd && (mq.size() > 0);
      ev_ok = 0; ev_bad = 0; ev_b = 8'h00;
      if (sched.size() > 0 && sched[0].at == cyc) begin
        ev = sched.pop_front();
        ev_ok = ev.ok; ev_bad = !ev.ok; ev_b = ev.b;
      end
      if (clr) begin ov_m = 0; fe_m = 0; end
      if (popm) void'(mq.pop_front());
      if (ev_ok) begin
        if (mq.size() < DEPTH) mq.push_back(ev_b);
        else ov_m = 1;
      end
      if (ev_bad) fe_m = 1;
    end
  end

  initial forever begin
    @(negedge HCLK);
    if (model_on) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("overrun", 32'(overrun), 32'(ov_m));
      chk("frame_err", 32'(frame_err), 32'(fe_m));
      if (mq.size() > 0) chk("rdata", 32'(rdata), 32'(mq[0]));
    end
  end

  task automatic idle(input int n);
    @(posedge HCLK); #1;
    rx = 1'b1;
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int hold_low_bits);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    @(posedge HCLK); #1;
    last_push = cyc + LAT;
    sched.push_back(ev_t'{last_push, b, stop_ok});
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CPB) @(posedge HCLK);
      #1;
    end
    if (hold_low_bits > 0) begin
      rx = 1'b0;
      repeat (hold_low_bits * CPB) @(posedge HCLK);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic pop_lit(input logic [7:0] exp);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("pop_head", 32'(rdata), 32'(exp));
    chk("pop_nonempty", 32'(empty), 32'(0));
    rd = 1'b1;
    @(posedge HCLK); #1;
    rd = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0; rx = 1'b1; rd = 1'b0; clr = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(negedge HCLK);
    chk("rst_empty", 32'(empty), 32'(1));
    chk("rst_full", 32'(full), 32'(0));
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_rdata", 32'(rdata), 32'(0));
    chk("rst_overrun", 32'(overrun), 32'(0));
    chk("rst_frame_err", 32'(frame_err), 32'(0));

    // Basic byte, with exact fall of empty
    idle(10);
    fork
      send_frame(8'h41, 1'b1, 0);
      begin
        @(posedge HCLK); #2;
        while (cyc < last_push - 1) begin @(posedge HCLK); #1; end
        @(negedge HCLK);
        chk("empty_before_push", 32'(empty), 32'(1));
        @(negedge HCLK);
        chk("empty_after_push", 32'(empty), 32'(0));
        chk("first_rdata", 32'(rdata), 32'(8'h41));
        chk("first_count", 32'(count), 32'(1));
      end
    join
    pop_lit(8'h41);
    @(negedge HCLK);
    chk("basic_drained", 32'(count), 32'(0));

    // Burst with concurrent pops; pointers wrap
    for (int i = 0; i < 6; i++) send_frame(8'(i), 1'b1, 0);
    fork
      for (int i = 6; i < 12; i++) send_frame(8'(i), 1'b1, 0);
      for (int j = 0; j < 4; j++) begin
        repeat (40) @(posedge HCLK);
        pop_lit(8'(j));
      end
    join
    idle(4);
    @(negedge HCLK);
    chk("burst_count", 32'(count), 32'(8));
    chk("burst_overrun", 32'(overrun), 32'(0));
    for (int j = 4; j < 12; j++) pop_lit(8'(j));

    // Glitch rejection
    @(posedge HCLK); #1 rx = 1'b0;
    repeat (5) @(posedge HCLK);
    #1 rx = 1'b1;
    idle(40);
    @(negedge HCLK);
    chk("glitch_count", 32'(count), 32'(0));
    chk("glitch_frame_err", 32'(frame_err), 32'(0));

    // Framing error followed by a long break, then a clean frame
    send_frame(8'h55, 1'b0, 40);
    idle(20);
    send_frame(8'h3C, 1'b1, 0);
    idle(4);
    @(negedge HCLK);
    chk("ferr_flag", 32'(frame_err), 32'(1));
    chk("ferr_count", 32'(count), 32'(1));
    pop_lit(8'h3C);

    // Overrun
    for (int i = 0; i < 9; i++) send_frame(8'hA0 + 8'(i), 1'b1, 0);
    idle(4);
    @(negedge HCLK);
    chk("ovr_full", 32'(full), 32'(1));
    chk("ovr_count", 32'(count), 32'(8));
    chk("ovr_flag", 32'(overrun), 32'(1));
    @(posedge HCLK); #1 clr = 1'b1;
    @(posedge HCLK); #1 clr = 1'b0;
    @(negedge HCLK);
    chk("clr_overrun", 32'(overrun), 32'(0));
    chk("clr_frame_err", 32'(frame_err), 32'(0));
    chk("clr_count", 32'(count), 32'(8));
    for (int i = 0; i < 8; i++) pop_lit(8'hA0 + 8'(i));

    // Full FIFO with a pop on the exact stop-sample cycle
    for (int i = 0; i < 8; i++) send_frame(8'hB0 + 8'(i), 1'b1, 0);
    fork
      send_frame(8'h7E, 1'b1, 0);
      begin
        repeat (3) @(posedge HCLK);
        #1;
        while (cyc < last_push - 1) begin @(posedge HCLK); #1; end
        rd = 1'b1;
        @(posedge HCLK); #1;
        rd = 1'b0;
      end
    join
    @(negedge HCLK);
    chk("simul_overrun", 32'(overrun), 32'(0));
    chk("simul_count", 32'(count), 32'(8));
    for (int i = 1; i < 8; i++) pop_lit(8'hB0 + 8'(i));
    pop_lit(8'h7E);

    // Randomized traffic with random pops and occasional bad stop bits
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          logic [7:0] b;
          bit ok;
          b  = 8'($urandom);
          ok = ($urandom_range(0, 6) != 0);
          send_frame(b, ok, ok ? 0 : int'($urandom_range(0, 3)));
          idle(int'($urandom_range(2, 30)));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge HCLK); #1;
          rd = ($urandom_range(0, 39) == 0);
        end
        rd = 1'b0;
      end
    join

    // Reset in the middle of DATA
    send_frame(8'hC1, 1'b1, 0);
    send_frame(8'hC2, 1'b1, 0);
    send_frame(8'h99, 1'b0, 0);
    idle(4);
    @(negedge HCLK);
    chk("pre_reset_frame_err", 32'(frame_err), 32'(1));
    @(posedge HCLK); #1 rx = 1'b0;
    repeat (CPB) @(posedge HCLK);
    for (int i = 0; i < 3; i++) begin
      #1 rx = i[0];
      repeat (CPB) @(posedge HCLK);
    end
    #1 HRESETn = 1'b0; rx = 1'b1;
    @(posedge HCLK); #1 HRESETn = 1'b1;
    @(negedge HCLK);
    chk("mid_rst_empty", 32'(empty), 32'(1));
    chk("mid_rst_count", 32'(count), 32'(0));
    chk("mid_rst_overrun", 32'(overrun), 32'(0));
    chk("mid_rst_frame_err", 32'(frame_err), 32'(0));
    idle(200);
    @(negedge HCLK);
    chk("post_rst_quiet", 32'(count), 32'(0));
    send_frame(8'h5A, 1'b1, 0);
    idle(4);
    @(negedge HCLK);
    chk("post_rst_rdata", 32'(rdata), 32'(8'h5A));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Synthesizable UART receiver with a receive FIFO. Consumes the serial TX line of the SoC UART (RsTx_Sys0_SS0_S0) and buffers the decoded bytes.
- Downstream capture stage for the UART0 path. Usable as an on-chip loopback peripheral or as a self-checking bench capture block.
- Frame format is fixed at 8N1, LSB first, idle high.

Parameters:
- CLKS_PER_BIT, 16, HCLK cycles per serial bit. Must be even and >= 4. At HCLK = 100 MHz this gives a 160 ns bit time.
- DEPTH, 8, FIFO entries. Must be a power of two, >= 2.
- CW, 4, width of the count output. Equals log2(DEPTH)+1.

Ports:
- HCLK  input  1  system clock
- HRESETn  input  1  synchronous active-low reset
- rx  input  1  asynchronous serial input, idle high
- rd  input  1  pop strobe; one byte popped per cycle while high and !empty
- clr  input  1  clears the sticky error flags
- rdata  output  8  FIFO head byte, first-word fall-through; valid when !empty
- empty  output  1  FIFO empty
- full  output  1  FIFO full
- count  output  CW  number of bytes held, 0..DEPTH
- overrun  output  1  sticky: a byte was dropped because the FIFO was full
- frame_err  output  1  sticky: the stop bit was sampled low

Behaviour:
- Clock and reset: single clock, HCLK. Reset is synchronous, active-low, on HRESETn, sampled on posedge HCLK.
- Reset values:
  - empty=1, full=0, count=0, rdata=0, overrun=0, frame_err=0.
  - FSM in IDLE; bit and clock counters at 0.
  - Synchronizer flops preset to 1.
- Input sync: rx passes through a 2-flop synchronizer, giving rx_s. All decoding uses rx_s.
- State machine (IDLE, START, DATA, STOP, BREAK):
  - IDLE: rx_s==0 → START, clock counter=0.
  - START: count to CLKS_PER_BIT/2-1 (mid start bit), then sample.
    - rx_s==1: glitch, → IDLE.
    - else → DATA, bit counter=0, clock counter=0.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift[bit] (LSB first). After bit 7 is sampled → STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - rx_s==1: push the byte, → IDLE.
    - rx_s==0: set frame_err, discard the byte, → BREAK.
  - BREAK: remain until rx_s==1, then → IDLE. Prevents a line held low from being decoded as 0x00 frames.
- Push:
  - Occurs on the stop-sample edge. empty deasserts and rdata is valid on the following cycle.
  - Total latency from the rx stop-bit midpoint to !empty: 2 synchronizer cycles + 1 cycle.
- FIFO:
  - Circular buffer. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is maintained explicitly.
  - rdata = mem[rptr] combinationally from registered storage.
  - rd while empty: ignored; no pointer change, no error flag.
  - Push while full with no simultaneous pop: byte dropped, overrun set, FIFO contents unchanged.
  - Push while full with a pop in the same cycle: both accepted; count stays DEPTH; no overrun.
  - Push and pop in the same cycle when count==1: count stays 1; rdata shows the new byte next cycle.
- Flags:
  - full = (count==DEPTH); empty = (count==0).
  - overrun and frame_err are sticky. They clear only on clr or reset.
  - clr asserted in the same cycle as a new error event: the set wins and the flag stays 1.
- Reset mid-frame: FSM returns to IDLE and the FIFO is emptied. The partially received byte is lost. The rest of that frame's bits are not treated as new start bits until a falling edge is seen from IDLE.

Test Plan:
- Basic byte: after reset, drive frame 0x41 at 16 clocks/bit, then idle high → empty falls 3 cycles after the stop midpoint; rdata=0x41, count=1. Pulse rd → empty=1, count=0.
- Burst and wrap: send 0x00..0x0B (12 bytes) while popping 4 after the 6th byte → read order 0x00..0x0B exact; count never exceeds 8; overrun=0; pointers wrap with no corruption.
- Overrun: send 9 bytes 0xA0..0xA8 without reading → full=1, count=8, overrun=1, FIFO holds 0xA0..0xA7. Pulse clr → overrun=0; contents unchanged.
- Framing error: send 0x55 with the stop bit low, hold rx low 40 bit times, then high, then a valid 0x3C → frame_err=1; only 0x3C enters the FIFO; no 0x00 bytes are captured.
- Glitch rejection: drive a 5-cycle low pulse on idle rx → FSM returns to IDLE; nothing pushed; no flags set.
- Simultaneous events: with FIFO full, assert rd on the exact stop-sample cycle of an incoming 0x7E → no overrun; count=8; 0x7E is the last entry. Assert HRESETn=0 mid-DATA of the next frame → empty=1, count=0, flags 0 one cycle later.
